onchip_mem_arbiter: RTL
=======================

Name: onchip_mem_arbiter

Overview:
- Two-requester round-robin arbiter in front of the single-port 32-bit on-chip RAM (1-cycle read latency: address registered in RAM, output unregistered).
- Shares the RAM between the CPU data master (port 0) and a DMA/streaming master (port 1).
- Presents an Avalon-MM slave with waitrequest/readdatavalid to each master and drives the RAM's address/byteenable/chipselect/write/writedata/clken.
- Also enforces the RAM depth and flags out-of-range accesses.

Parameters:
- ADDR_W, 15, word-address width of the RAM and both slave ports
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- DEPTH, 30720, number of valid words; address >= DEPTH is out of range
- FIXED_PRIO, 0, 1 = port 0 always wins; 0 = round-robin

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- m0_address  in  ADDR_W  port 0 word address
- m0_read  in  1  port 0 read request
- m0_write  in  1  port 0 write request
- m0_byteenable  in  BE_W  port 0 byte lanes
- m0_writedata  in  DATA_W  port 0 write data
- m0_waitrequest  out  1  port 0 stall
- m0_readdata  out  DATA_W  port 0 read data
- m0_readdatavalid  out  1  port 0 read data valid
- m1_*  same set as m0_*  port 1
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  BE_W  RAM byte lanes
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM q
- err_oob  out  1  sticky out-of-range flag
- err_clr  in  1  clears err_oob

Behaviour:
- Request: reqX = mX_read | mX_write. Read and write both high on one port: treat as write.
- Arbitration (combinational, every cycle):
  - Only one port requesting: that port is granted.
  - Both requesting, FIXED_PRIO=1: port 0 granted.
  - Both requesting, FIXED_PRIO=0: port other than last_grant granted.
  - last_grant is a register, updated on every grant; reset value 1, so port 0 wins the first tie.
- Handshake:
  - mX_waitrequest = ~grantX. Asserted while idle and throughout reset.
  - A transaction is accepted in a cycle where reqX=1 and waitrequest=0.
  - A master holds its signals stable while stalled.
  - At most one transaction is accepted per cycle in total.
- RAM drive (combinational from the granted port):
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted port; with no grant they hold the last granted values.
  - mem_chipselect = grant_any & in_range.
  - mem_write = chipselect & granted write.
  - mem_clken = reset_n.
- Read return, for a read accepted at edge N:
  - Registers rd_pend and rd_port are set at edge N.
  - During cycle N+1: mX_readdatavalid = rd_pend & (rd_port==X); mX_readdata = mem_readdata for the owner.
  - Non-owner readdata = 0.
  - Back-to-back reads, including reads alternating between ports: one readdatavalid per cycle, in issue order.
  - Writes produce no readdatavalid.
- Out of range (address >= DEPTH): the transaction is still accepted (no deadlock).
  - Write: RAM untouched.
  - Read: returns readdatavalid at N+1 with readdata=0.
  - err_oob is set at edge N.
  - err_clr clears err_oob. A set in the same cycle as err_clr wins.
- Reset (reset_n=0 sampled at an edge):
  - Registers: rd_pend=0, last_grant=1, err_oob=0.
  - Outputs: readdatavalid=0, readdata=0, waitrequest=1, chipselect=0, mem_write=0.
  - Captured mux hold values = 0.
  - A read pending when reset is asserted is discarded and never returned.
- No combinational path from mem_readdata to any waitrequest.

Test Plan:
- Port 0 writes 0xA5A5_1234 at addr 0x0010 with be=4'b1111, then reads it -> waitrequest=0 on both access cycles; readdatavalid on port 0 exactly 1 cycle after the read is accepted; readdata=0xA5A5_1234.
- Both ports read continuously with FIXED_PRIO=0 -> grants alternate 0,1,0,1 starting with port 0; each readdatavalid goes only to the issuing port, one cycle after issue; no lost or duplicated beats over 100 cycles.
- Same stimulus with FIXED_PRIO=1 -> port 1 waitrequest held high the whole time; port 1 is granted the cycle after port 0 drops its request.
- Port 1 writes 0xFFFF_FFFF at addr 0x20 with be=4'b0101 over an initial 0 -> readback gives 0x00FF_00FF.
- Port 0 writes to addr 30720, then reads addr 30721 -> both accepted; RAM unchanged; read returns 0 with readdatavalid; err_oob=1 until err_clr is pulsed, then 0.
- Read accepted at edge N, reset_n low at edge N+1 -> no readdatavalid in any subsequent cycle; all waitrequests high during reset; after release, port 0 wins the first tie.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Purpose:
//   Shares one single-port on-chip RAM between two Avalon-MM masters. Port 0
//   is the CPU data master and port 1 is the DMA/streaming master. Each cycle
//   the arbiter grants at most one request. Ties are broken round-robin, or
//   always in favour of port 0 when FIXED_PRIO=1. Accesses at or beyond DEPTH
//   are still accepted, so a master can never deadlock on them. They leave
//   the RAM untouched, reads return zero, and they set the sticky err_oob.
//
// Ports:
//   clk, reset_n          single clock, synchronous active-low reset
//   mX_address/read/write/byteenable/writedata   master X request (X = 0, 1)
//   mX_waitrequest        stall; this is simply the inverse of the grant
//   mX_readdata/valid     read return, one cycle after the read is accepted
//   mem_*                 RAM drive; the RAM registers its address and has an
//                         unregistered q output (mem_readdata)
//   err_oob, err_clr      sticky out-of-range flag and its clear
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int BE_W       = 4,
    parameter int DEPTH      = 30720,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              err_oob,
    input  logic              err_clr
);

    // One extra bit so that DEPTH = 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // Both ports are gathered into arrays so the mux and the read return
    // are indexed by port number.
    logic [1:0]        req;
    logic [1:0]        wr_req;
    logic [ADDR_W-1:0] addr_a [2];
    logic [BE_W-1:0]   be_a   [2];
    logic [DATA_W-1:0] wd_a   [2];

    assign req[0]    = m0_read | m0_write;
    assign req[1]    = m1_read | m1_write;
    assign wr_req[0] = m0_write;          // read+write together counts as a write
    assign wr_req[1] = m1_write;
    assign addr_a[0] = m0_address;
    assign addr_a[1] = m1_address;
    assign be_a[0]   = m0_byteenable;
    assign be_a[1]   = m1_byteenable;
    assign wd_a[0]   = m0_writedata;
    assign wd_a[1]   = m1_writedata;

    // State
    logic              last_grant_reg;    // port granted most recently
    logic              rd_pend_reg;       // a read was accepted at the last edge
    logic              rd_port_reg;       // owner of that read
    logic              rd_oob_reg;        // that read was out of range
    logic              err_oob_reg;
    logic [ADDR_W-1:0] addr_hold_reg;     // RAM bus holds these values while idle
    logic [BE_W-1:0]   be_hold_reg;
    logic [DATA_W-1:0] wd_hold_reg;

    // Arbitration
    logic [1:0] grant;
    logic       grant_any;
    logic       gnt_port;
    logic       g_write;
    logic       in_range;

    always_comb begin
        grant = 2'b00;
        // While reset is held, nothing is granted, so every waitrequest is high.
        if (reset_n) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11: begin
                    if (FIXED_PRIO != 0)
                        grant = 2'b01;
                    else
                        grant = last_grant_reg ? 2'b01 : 2'b10;
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_any = |grant;
    assign gnt_port  = grant[1];
    assign g_write   = grant_any & wr_req[gnt_port];

    assign m0_waitrequest = ~grant[0];
    assign m1_waitrequest = ~grant[1];

    // RAM drive
    assign mem_address    = grant_any ? addr_a[gnt_port] : addr_hold_reg;
    assign mem_byteenable = grant_any ? be_a[gnt_port]   : be_hold_reg;
    assign mem_writedata  = grant_any ? wd_a[gnt_port]   : wd_hold_reg;
    assign in_range       = {1'b0, mem_address} < DEPTH_LIM;
    assign mem_chipselect = grant_any & in_range;
    assign mem_write      = mem_chipselect & g_write;
    assign mem_clken      = reset_n;
    assign err_oob        = err_oob_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_reg <= 1'b1;       // lets port 0 win the first tie
            rd_pend_reg    <= 1'b0;       // an in-flight read is dropped
            rd_port_reg    <= 1'b0;
            rd_oob_reg     <= 1'b0;
            err_oob_reg    <= 1'b0;
            addr_hold_reg  <= '0;
            be_hold_reg    <= '0;
            wd_hold_reg    <= '0;
        end else begin
            rd_pend_reg <= grant_any & ~g_write;
            if (grant_any) begin
                last_grant_reg <= gnt_port;
                rd_port_reg    <= gnt_port;
                rd_oob_reg     <= ~in_range;
                addr_hold_reg  <= addr_a[gnt_port];
                be_hold_reg    <= be_a[gnt_port];
                wd_hold_reg    <= wd_a[gnt_port];
            end
            // If a new violation and a clear arrive in the same cycle, the
            // violation wins.
            if (grant_any && !in_range)
                err_oob_reg <= 1'b1;
            else if (err_clr)
                err_oob_reg <= 1'b0;
        end
    end

    // Read return
    // Gating with reset_n means a read that is still in flight when reset
    // arrives is never returned, even during the cycle before the reset edge.
    // Out-of-range reads return zero instead of whatever the RAM drives.
    logic              rd_valid;
    logic [DATA_W-1:0] ret_data;
    logic [1:0]        rdv;
    logic [DATA_W-1:0] rdat_a [2];

    assign rd_valid = rd_pend_reg & reset_n;
    assign ret_data = rd_oob_reg ? '0 : mem_readdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        assign rdv[gi]    = rd_valid & (rd_port_reg == 1'(gi));
        assign rdat_a[gi] = rdv[gi] ? ret_data : '0;
    end

    assign m0_readdatavalid = rdv[0];
    assign m1_readdatavalid = rdv[1];
    assign m0_readdata      = rdat_a[0];
    assign m1_readdata      = rdat_a[1];

endmodule
